flash_read_responder: RTL and testbench
=======================================

# flash_read_responder

Avalon-MM read-only slave that answers the read master used by the audio playback path. It sits in place of the flash device in simulation and in the on-chip sample-store build, serving 32-bit words from an internal word-addressed memory. The memory is preloaded through a side load port. Responses use `waitRequest`/`readDataValid` with a fixed, parameterised read latency and a bounded number of outstanding reads.

## Interface
Parameters:
- `ADDR_W`, 8: memory index width; depth = 2^ADDR_W 32-bit words.
- `LATENCY`, 3: cycles from read acceptance to `readDataValid`; legal range 1..8.
- `MAX_PENDING`, 2: maximum accepted-but-unreturned reads; legal range 1..8.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-low.
- `read` in 1: read request from the master.
- `address` in 24: word address.
- `byteEnable` in 4: lane enables for the read.
- `waitRequest` out 1: master must hold the request; no accept this cycle.
- `readData` out 32: returned word.
- `readDataValid` out 1: one-cycle pulse; `readData` is valid.
- `load` in 1: write `load_data` into memory at `load_address`.
- `load_address` in ADDR_W: memory index for the load.
- `load_data` in 32: word to store.
- `pending` out 4: count of outstanding reads.
- `range_error` out 1: sticky; set when an accepted read has `address` ≥ 2^ADDR_W.

## Operation
- **Accept rule:** a read is accepted in cycle T when `read`=1 and `waitRequest`=0 in T. `waitRequest` = (`pending` == MAX_PENDING) OR (`reset`=0). It is combinational from registered state only, never from `read`.
- **Data capture:** at acceptance, the word at `address[ADDR_W-1:0]` is read and masked. Byte lane i is forced to 8'h00 when `byteEnable[i]`=0. The masked word enters a LATENCY-deep valid/data shift pipeline.
- **Out-of-range reads:** if `address[23:ADDR_W]` ≠ 0, the returned word is 32'h0000_0000 and `range_error` is set. The read still returns normally.
- **Ordering:** responses are returned strictly in acceptance order, one per accepted read. No response is ever dropped or duplicated outside reset.
- **Pending counter:**
  - +1 on acceptance; −1 at the end of a cycle with `readDataValid`=1.
  - Both in the same cycle leave it unchanged.
  - A read accepted in the same cycle as a response is legal only when `pending` < MAX_PENDING.
- **`readData` between pulses:** holds the last returned word.
- **Loads:**
  - `load`=1 writes memory at the clock edge ending the cycle. Loads are always accepted, independent of reads.
  - A load and an accepted read to the same index in the same cycle: the read returns the old contents.
  - A load to an index with a read already in flight does not change that in-flight data.
- **Reset:** memory contents are not cleared. Reset empties the pipeline, so in-flight reads are discarded and produce no `readDataValid` after reset.

## Timing
- **Reset values (cycle after an edge with `reset`=0):**
  - `readDataValid`=0, `readData`=32'h0, `pending`=0, `range_error`=0.
  - `waitRequest`=1 while `reset`=0; it drops to 0 in the first cycle with `reset`=1.
- **Latency:** a read accepted in cycle T gives `readDataValid`=1 in cycle T+LATENCY, for exactly one cycle. LATENCY=1 returns in the next cycle.
- **Throughput:**
  - Back-to-back accepts are allowed until `pending` reaches MAX_PENDING.
  - With MAX_PENDING ≥ LATENCY+1, one read per cycle is sustained.
  - Otherwise `waitRequest` rises in the cycle after the accept that fills the counter. It falls in the cycle after the oldest response's `readDataValid` cycle.
- **Master hold:** while `waitRequest`=1, the master holds `read`, `address` and `byteEnable`. The responder ignores them (no capture) until the accept cycle.
- **`range_error`:** sets in the cycle after the accepting cycle and clears only on reset.
- **Load timing:** a load in cycle L is visible to reads accepted in cycle L+1 or later.

## Test plan
- **Basic read:** LATENCY=3; load index 5 with 32'hA1B2C3D4; read address 5 with byteEnable 4'b1111, accepted at T → `readDataValid`=1 only at T+3, `readData`=32'hA1B2C3D4, `pending` 1→0 after T+3.
- **Byte masking:** same word, byteEnable 4'b0101 → 32'h00B200D4; byteEnable 4'b0000 → valid pulse with 32'h0.
- **Backpressure:** LATENCY=3, MAX_PENDING=2; hold `read`=1 on addresses 0,1,2 (preloaded 10,11,12) →
  - accepts at T and T+1; `waitRequest`=1 for T+2..T+3;
  - third read accepted at T+4;
  - data 10,11,12 valid at T+3, T+4, T+7 in order.
- **Same-cycle collision:** load index 7 = 32'h2 while reading index 7, which holds 32'h1 → returns 32'h1; a read in the next cycle returns 32'h2.
- **Out of range:** ADDR_W=8, read address 24'h000100 → `readData`=32'h0, `readDataValid` pulse, `range_error`=1 and held until reset.
- **Reset mid-flight:** accept two reads, then assert `reset`=0 for one cycle at T+1 → no `readDataValid` afterwards, `pending`=0, `waitRequest`=1 during reset, memory contents intact on re-read.

Source files
------------

// File: rtl/flash_read_responder_if.sv
// Avalon-MM read-only slave bus plus the side load port and status outputs
// of the flash read responder.
interface flash_read_responder_if #(
    parameter int ADDR_W = 8
);
    logic              read;
    logic [23:0]       address;
    logic [3:0]        byteEnable;
    logic              waitRequest;
    logic [31:0]       readData;
    logic              readDataValid;
    logic              load;
    logic [ADDR_W-1:0] load_address;
    logic [31:0]       load_data;
    logic [3:0]        pending;
    logic              range_error;

    modport master (
        output read, address, byteEnable, load, load_address, load_data,
        input  waitRequest, readData, readDataValid, pending, range_error
    );

    modport slave (
        input  read, address, byteEnable, load, load_address, load_data,
        output waitRequest, readData, readDataValid, pending, range_error
    );
endinterface

// File: rtl/flash_read_responder.sv
// Read-only Avalon-MM responder serving 32-bit words from a preloadable memory
// with a fixed read latency and a bounded number of outstanding reads.
module flash_read_responder #(
    parameter int ADDR_W      = 8,
    parameter int LATENCY     = 3,
    parameter int MAX_PENDING = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    flash_read_responder_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0]        mem [DEPTH];
    logic [LATENCY-1:0] vld_q;
    logic [31:0]        dat_q [LATENCY];
    logic [31:0]        last_q;
    logic [3:0]         pending_q;
    logic               range_q;

    logic               wait_req;
    logic               accept;
    logic               out_of_range;
    logic [31:0]        lane_mask;
    logic [31:0]        read_word;
    logic               resp_valid;

    // waitRequest depends only on registered state and reset, never on read.
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        wait_req     = (pending_q == 4'(MAX_PENDING)) || !reset;
        accept       = bus.read && !wait_req;
        out_of_range = |(bus.address >> ADDR_W);
        lane_mask    = {{8{bus.byteEnable[3]}}, {8{bus.byteEnable[2]}},
                        {8{bus.byteEnable[1]}}, {8{bus.byteEnable[0]}}};
        read_word    = 32'h0;
        if (!out_of_range) begin
            read_word = mem[bus.address[ADDR_W-1:0]] & lane_mask;
        end
        resp_valid   = vld_q[LATENCY-1];
    end

    // Asynchronous read above sees the pre-edge contents, so a same-cycle load
    // to the index being read returns the old word.
    // NOTE: memory and data pipeline carry no reset; only the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (bus.load) begin
            mem[bus.load_address] <= bus.load_data;
        end
        dat_q[0] <= read_word;
        for (int i = 1; i < LATENCY; i++) begin
            dat_q[i] <= dat_q[i-1];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_q     <= '0;
            pending_q <= 4'd0;
            range_q   <= 1'b0;
            last_q    <= 32'h0;
        end else begin
            vld_q[0] <= accept;
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
            case ({accept, resp_valid})
                2'b10:   pending_q <= pending_q + 4'd1;
                2'b01:   pending_q <= pending_q - 4'd1;
                default: pending_q <= pending_q;
            endcase
            if (accept && out_of_range) begin
                range_q <= 1'b1;
            end
            if (resp_valid) begin
                last_q <= dat_q[LATENCY-1];
            end
        end
    end

    assign bus.waitRequest   = wait_req;
    assign bus.readDataValid = resp_valid;
    assign bus.readData      = resp_valid ? dat_q[LATENCY-1] : last_q;
    assign bus.pending       = pending_q;
    assign bus.range_error   = range_q;
endmodule

// File: tb/tb_flash_read_responder.sv
// Scoreboard bench for flash_read_responder: stimulus pushes expected words and
// return cycles; a monitor pops and compares on every readDataValid pulse.
module tb_flash_read_responder;
    localparam int ADDR_W      = 8;
    localparam int LATENCY     = 3;
    localparam int MAX_PENDING = 2;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   total;
    int   bad;
    exp_t sb[$];

    flash_read_responder_if #(.ADDR_W(ADDR_W)) bus ();

    flash_read_responder #(
        .ADDR_W(ADDR_W), .LATENCY(LATENCY), .MAX_PENDING(MAX_PENDING)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every response must match the oldest expectation in word and cycle.
    always @(negedge clk) begin
        if (bus.readDataValid === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_valid", 32'(bus.readDataValid), 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("resp_data", bus.readData, e.data);
                check("resp_cycle", 32'(cyc), 32'(e.due));
            end
        end
    end

    task automatic do_load(input logic [ADDR_W-1:0] idx, input logic [31:0] data);
        bus.load         = 1'b1;
        bus.load_address = idx;
        bus.load_data    = data;
        @(posedge clk); #1;
        bus.load = 1'b0;
    endtask

    // Holds the request until accepted; returns the accept cycle.
    task automatic issue(input logic [23:0] addr, input logic [3:0] be,
                         input logic [31:0] exp, input bit push, output int t_acc);
        int n;
        bus.read       = 1'b1;
        bus.address    = addr;
        bus.byteEnable = be;
        n = 0;
        @(negedge clk);
        while (bus.waitRequest !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("accept_timeout", 32'(n), 32'h0);
        t_acc = cyc;
        if (push) sb.push_back('{data: exp, due: cyc + LATENCY});
        @(posedge clk); #1;
        bus.read = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue_empty", 32'(sb.size()), 32'h0);
        @(negedge clk);
        check("drain_pending_zero", 32'(bus.pending), 32'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, t2, tx;
        total = 0;
        bad   = 0;
        reset = 1'b0;
        bus.read = 1'b0; bus.address = 24'h0; bus.byteEnable = 4'h0;
        bus.load = 1'b0; bus.load_address = '0; bus.load_data = 32'h0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(bus.readDataValid), 32'h0);
        check("rst_data", bus.readData, 32'h0);
        check("rst_pending", 32'(bus.pending), 32'h0);
        check("rst_range_error", 32'(bus.range_error), 32'h0);
        check("rst_waitrequest", 32'(bus.waitRequest), 32'h1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_waitrequest", 32'(bus.waitRequest), 32'h0);
        @(posedge clk); #1;

        do_load(8'd5, 32'hA1B2C3D4);
        do_load(8'd0, 32'd10);
        do_load(8'd1, 32'd11);
        do_load(8'd2, 32'd12);
        do_load(8'd7, 32'h1);

        // Basic read: pending is 1 in the cycle after the accept.
        issue(24'd5, 4'b1111, 32'hA1B2C3D4, 1'b1, t0);
        @(negedge clk);
        check("basic_pending_one", 32'(bus.pending), 32'h1);
        @(posedge clk); #1;
        drain();

        // Byte lane masking.
        issue(24'd5, 4'b0101, 32'h00B200D4, 1'b1, t0);
        issue(24'd5, 4'b0000, 32'h00000000, 1'b1, t0);
        drain();
        issue(24'd5, 4'b1010, 32'hA100C300, 1'b1, t0);
        drain();

        // Backpressure with MAX_PENDING=2: accepts at T, T+1, T+4.
        issue(24'd0, 4'b1111, 32'd10, 1'b1, t0);
        issue(24'd1, 4'b1111, 32'd11, 1'b1, t1);
        issue(24'd2, 4'b1111, 32'd12, 1'b1, t2);
        check("bp_second_accept", 32'(t1 - t0), 32'd1);
        check("bp_third_accept", 32'(t2 - t0), 32'd4);
        drain();

        // Same-cycle load and read to index 7 returns the old word.
        bus.load = 1'b1; bus.load_address = 8'd7; bus.load_data = 32'h2;
        issue(24'd7, 4'b1111, 32'h1, 1'b1, t0);
        bus.load = 1'b0;
        issue(24'd7, 4'b1111, 32'h2, 1'b1, t1);
        check("collision_back_to_back", 32'(t1 - t0), 32'd1);
        drain();

        // Out-of-range reads return zero and set the sticky flag.
        check("range_error_clear", 32'(bus.range_error), 32'h0);
        issue(24'h000100, 4'b1111, 32'h0, 1'b1, t0);
        @(negedge clk);
        check("range_error_set", 32'(bus.range_error), 32'h1);
        @(posedge clk); #1;
        issue(24'h800005, 4'b1111, 32'h0, 1'b1, t0);
        drain();
        check("range_error_sticky", 32'(bus.range_error), 32'h1);

        // Reset with two reads in flight: no responses may follow.
        issue(24'd0, 4'b1111, 32'd10, 1'b0, t0);
        issue(24'd1, 4'b1111, 32'd11, 1'b0, t1);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_waitrequest", 32'(bus.waitRequest), 32'h1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("midrst_pending", 32'(bus.pending), 32'h0);
        check("midrst_range_error", 32'(bus.range_error), 32'h0);
        check("midrst_waitrequest_low", 32'(bus.waitRequest), 32'h0);
        repeat (8) @(negedge clk);
        check("midrst_pending_idle", 32'(bus.pending), 32'h0);
        @(posedge clk); #1;

        // Memory survives reset.
        issue(24'd5, 4'b1111, 32'hA1B2C3D4, 1'b1, tx);
        issue(24'd7, 4'b1111, 32'h2, 1'b1, tx);
        drain();
        check("hold_last_word", bus.readData, 32'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
